// File: rtl/stair_light_ctrl.sv
// Two-way staircase light: a debounced change on either switch flips the lamp.
// Define STAIR_LIGHT_TIMEOUT_EN to compile in the auto-off timer.
module stair_light_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic c,
  output logic expired,
  output logic ready
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int IW = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("stair_light_ctrl: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {S_INIT, S_OFF, S_ON} state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          sync_prev_q, sync_prev_d;
  logic [1:0]          acc_q, acc_d;
  logic [1:0]          acc_prev_q, acc_prev_d;
  logic [1:0][DW-1:0]  db_cnt_q, db_cnt_d;
  logic [IW-1:0]       init_cnt_q, init_cnt_d;
  logic                c_q, c_d;
  logic                ready_q, ready_d;
  logic                toggle;

`ifdef STAIR_LIGHT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          expired_q, expired_d;
`endif

  // Both accepted levels changing together cancel out.
  assign toggle = ^(acc_q ^ acc_prev_q);

  always_comb begin
    sync1_d     = {b, a};
    sync2_d     = sync1_q;
    sync_prev_d = sync2_q;
    acc_d       = acc_q;
    acc_prev_d  = acc_q;
    db_cnt_d    = db_cnt_q;
    init_cnt_d  = init_cnt_q;
    state_d     = state_q;
`ifdef STAIR_LIGHT_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    expired_d   = 1'b0;
`endif

    // A fresh edge on the synchronized level restarts the count.
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == acc_q[i] || sync2_q[i] != sync_prev_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        acc_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end

    case (state_q)
      S_INIT: begin
        acc_d      = sync2_q;
        acc_prev_d = sync2_q;
        db_cnt_d   = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = S_OFF;
          init_cnt_d = '0;
        end
      end
      S_OFF: begin
        if (toggle) begin
          state_d = S_ON;
`ifdef STAIR_LIGHT_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      S_ON: begin
`ifdef STAIR_LIGHT_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (toggle) begin
          state_d = S_OFF;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_OFF;
          expired_d = 1'b1;
        end
`else
        if (toggle) begin
          state_d = S_OFF;
        end
`endif
      end
      default: state_d = S_INIT;
    endcase

    c_d     = (state_d == S_ON);
    ready_d = (state_d != S_INIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_prev_q <= '0;
      acc_q       <= '0;
      acc_prev_q  <= '0;
      db_cnt_q    <= '0;
      init_cnt_q  <= '0;
      c_q         <= 1'b0;
      ready_q     <= 1'b0;
`ifdef STAIR_LIGHT_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      expired_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_prev_q <= sync_prev_d;
      acc_q       <= acc_d;
      acc_prev_q  <= acc_prev_d;
      db_cnt_q    <= db_cnt_d;
      init_cnt_q  <= init_cnt_d;
      c_q         <= c_d;
      ready_q     <= ready_d;
`ifdef STAIR_LIGHT_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      expired_q   <= expired_d;
`endif
    end
  end

  assign c     = c_q;
  assign ready = ready_q;
`ifdef STAIR_LIGHT_TIMEOUT_EN
  assign expired = expired_q;
`else
  assign expired = 1'b0;
`endif

endmodule

// File: doc/stair_light_ctrl.md
STAIR_LIGHT_CTRL -- requirements
Module: stair_light_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive cycles a synchronized switch level must hold to be accepted (minimum 2).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000000, the number of cycles the light stays ON before auto-off (minimum 2, only used when the timeout is compiled in).
REQ-003 Port clk: input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-005 Port a: input, 1 bit, asynchronous raw switch A.
REQ-006 Port b: input, 1 bit, asynchronous raw switch B.
REQ-007 Port c: output, 1 bit, registered light drive, 1 = on.
REQ-008 Port expired: output, 1 bit, one-cycle pulse when the auto-off fires.
REQ-009 Port ready: output, 1 bit, 1 once INIT has completed.

Function
REQ-010 Each of a and b SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Per input: a debounce counter SHALL clear whenever the synchronized level equals the accepted level, or whenever the synchronized level changes; the accepted level SHALL update when the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-012 A toggle event SHALL occur in the cycle exactly one accepted level (a or b) changes; simultaneous changes of both in the same cycle SHALL cancel, with no event (XOR semantics).
REQ-013 The FSM SHALL have states INIT, OFF and ON, with c = 1 only in ON, driven from a register.
REQ-014 INIT: the FSM SHALL stay in INIT for DEBOUNCE_CYCLES+2 cycles after reset release; accepted levels SHALL load directly from the synchronizers with no events; the FSM SHALL then go to OFF and ready SHALL become 1.
REQ-015 OFF: a toggle event SHALL move the FSM to ON and clear the timeout counter.
REQ-016 ON: a toggle event SHALL move the FSM to OFF.
REQ-017 Latency: a clean input level change that first meets setup at edge N SHALL change c at edge N+DEBOUNCE_CYCLES+3.
REQ-018 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event and no change on c.
REQ-019 expired SHALL be 0 in every cycle except the auto-off cycle defined in REQ-024.

Reset
REQ-020 While rst = 1: the FSM SHALL be INIT; c, expired and ready SHALL be 0; synchronizers, accepted levels and all counters SHALL be 0; this SHALL take effect immediately, without a clock edge.
REQ-021 Reset asserted mid-operation (including ON with a partial timeout count) SHALL abandon all state; after release the block SHALL re-run INIT.

Configuration
REQ-022 Macro STAIR_LIGHT_TIMEOUT_EN SHALL compile the auto-off timer in or out.
REQ-023 With the macro: in ON, a counter SHALL increment each cycle from 0.
REQ-024 With the macro: in the cycle the counter equals TIMEOUT_CYCLES-1 with no toggle event, the FSM SHALL go to OFF and expired SHALL pulse for 1 cycle.
REQ-025 With the macro: a toggle event in the same cycle as the expiry SHALL take priority, going to OFF without an expired pulse.
REQ-026 Without the macro: no timeout counter SHALL exist; ON SHALL persist until a toggle event; expired SHALL be tied to 0.

Verification
REQ-027 Reset with a=1, b=0, then release -> ready=1 after DEBOUNCE_CYCLES+2 cycles, and c stays 0 (no spurious toggle).
REQ-028 After ready, raise a and hold -> c=1 exactly DEBOUNCE_CYCLES+3 edges later; then raise b -> c=0.
REQ-029 Pulse a high for 5 cycles with DEBOUNCE_CYCLES=16 -> c unchanged and no event.
REQ-030 Change a and b on the same edge and hold both -> accepted levels both update in one cycle, c unchanged.
REQ-031 With STAIR_LIGHT_TIMEOUT_EN and TIMEOUT_CYCLES=100, turn on and leave idle -> c=0 and expired=1 for 1 cycle, 100 cycles after c rose; a toggle landing on the expiry cycle -> c=0 with expired=0.
REQ-032 Assert rst asynchronously between edges while c=1 -> c=0 immediately, before the next edge, and INIT repeats after release.
